// File: rtl/nco_pkg.sv
// nco_pkg: shared state type, default widths and LFSR constants for the
// phase accumulator NCO and its optional dither generator.
package nco_pkg;

    // Tuning-word update state of the accumulator control
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } nco_state_e;

    // Default accumulator and output phase widths (1024-entry sine table)
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_PHASE_WIDTH = 10;

    // 16-bit maximal-length Galois LFSR used for phase dither
    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/lfsr_dither.sv
// lfsr_dither: right-shifting Galois LFSR that supplies pseudo-random dither
// for the phase truncation path. Reloads its seed on reset and only steps on
// cycles where the accumulator is enabled, so the dither sequence is tied to
// accumulated samples rather than wall-clock cycles.
module lfsr_dither
    import nco_pkg::*;
#(
    parameter int                WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED,
    parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_lfsr
);

    logic [WIDTH-1:0] lfsr_p0;
    logic [WIDTH-1:0] lfsr_nxt;

    // Galois step: shift right, fold the taps in when the outgoing bit is 1
    always_comb begin
        lfsr_nxt = lfsr_p0 >> 1;
        if (lfsr_p0[0]) begin
            lfsr_nxt = lfsr_nxt ^ TAPS;
        end
    end

    // LFSR register, stepping only on enabled cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_p0 <= SEED;
        end else if (i_en) begin
            lfsr_p0 <= lfsr_nxt;
        end
    end

    assign o_lfsr = lfsr_p0;

endmodule

// File: rtl/phase_accum_nco.sv
// phase_accum_nco: phase accumulator that drives the sine lookup phase input.
// Adds the active frequency tuning word every enabled cycle, truncates the
// accumulator to PHASE_WIDTH bits, adds a per-cycle phase offset and registers
// the result together with a valid flag and a once-per-period wrap pulse.
// New tuning words arrive over a valid/ready handshake; with UPDATE_ON_WRAP=1
// a word accepted while running is parked in a shadow register and only takes
// effect at the next accumulator wrap so a frequency hop never lands mid-period.
//
// Build option: define PHASE_DITHER_EN to add LFSR dither to the truncation
// path (the accumulator and the wrap pulse are never dithered). Without it the
// output phase is plain truncation and no LFSR is built.
module phase_accum_nco
    import nco_pkg::*;
#(
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int UPDATE_ON_WRAP = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_clear,
    input  logic [ACC_WIDTH-1:0]   i_ftw,
    input  logic                   i_ftw_valid,
    output logic                   o_ftw_ready,
    input  logic [PHASE_WIDTH-1:0] i_phase_ofs,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_valid,
    output logic                   o_wrap
);

    // Truncate an accumulator value to its top bits and add the phase offset;
    // the sum wraps naturally modulo 2^PHASE_WIDTH.
    function automatic logic [PHASE_WIDTH-1:0] phase_word(
        input logic [ACC_WIDTH-1:0]   acc,
        input logic [PHASE_WIDTH-1:0] ofs
    );
        return acc[ACC_WIDTH-1 -: PHASE_WIDTH] + ofs;
    endfunction

    // Control state
    nco_state_e           state_p0;
    nco_state_e           state_nxt;
    logic [ACC_WIDTH-1:0] ftw_active;
    logic [ACC_WIDTH-1:0] ftw_active_nxt;
    logic [ACC_WIDTH-1:0] ftw_shadow;
    logic [ACC_WIDTH-1:0] ftw_shadow_nxt;
    logic                 ftw_ready;
    logic                 ftw_hs;

    // Accumulator datapath
    logic [ACC_WIDTH-1:0] acc_p0;
    logic                 carry_p0;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 acc_step;
    logic                 wrap_now;
    logic [ACC_WIDTH-1:0] acc_trunc;

    assign ftw_hs   = i_ftw_valid & ftw_ready;
    assign acc_step = i_en & ~i_clear;
    assign acc_sum  = {1'b0, acc_p0} + {1'b0, ftw_active};
    // Carry-out of the accumulation actually taking place this cycle; a clear
    // suppresses the add and therefore any wrap.
    assign wrap_now = acc_step & acc_sum[ACC_WIDTH];

    // Next-state and tuning-word routing for the update FSM
    always_comb begin
        state_nxt      = state_p0;
        ftw_active_nxt = ftw_active;
        ftw_shadow_nxt = ftw_shadow;
        case (state_p0)
            IDLE: begin
                // Not accumulating, so a new word can be applied at once
                if (ftw_hs) begin
                    ftw_active_nxt = i_ftw;
                end
                if (i_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ftw_hs && (UPDATE_ON_WRAP != 0)) begin
                    // Park the word until the current period completes; a wrap
                    // in this same cycle does not count, the next one does.
                    ftw_shadow_nxt = i_ftw;
                    state_nxt      = PEND;
                end else begin
                    if (ftw_hs) begin
                        ftw_active_nxt = i_ftw;
                    end
                    if (!i_en) begin
                        state_nxt = IDLE;
                    end
                end
            end
            PEND: begin
                // The wrapping add itself still uses the old word; the shadow
                // becomes active for the first add of the new period. While
                // disabled or cleared no wrap can occur, so the update waits.
                if (wrap_now) begin
                    ftw_active_nxt = ftw_shadow;
                    state_nxt      = i_en ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers; ready is held low for the first cycle out of reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p0   <= IDLE;
            ftw_active <= '0;
            ftw_shadow <= '0;
            ftw_ready  <= 1'b0;
        end else begin
            state_p0   <= state_nxt;
            ftw_active <= ftw_active_nxt;
            ftw_shadow <= ftw_shadow_nxt;
            ftw_ready  <= (state_nxt != PEND);
        end
    end

    assign o_ftw_ready = ftw_ready;

    // ---- stage p0: phase accumulator with registered carry-out ----

    // Accumulate on enabled cycles; clear zeroes the phase without touching
    // the FSM or the tuning words, so a pending update stays pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_p0   <= '0;
            carry_p0 <= 1'b0;
        end else if (i_clear) begin
            acc_p0   <= '0;
            carry_p0 <= 1'b0;
        end else if (i_en) begin
            {carry_p0, acc_p0} <= acc_sum;
        end
    end

`ifdef PHASE_DITHER_EN
    // Dither spans the bits discarded by truncation, limited to the LFSR width
    localparam int DITH_W = ((ACC_WIDTH - PHASE_WIDTH) > LFSR_WIDTH) ?
                            LFSR_WIDTH : (ACC_WIDTH - PHASE_WIDTH);

    logic [LFSR_WIDTH-1:0] lfsr_val;
    logic [DITH_W-1:0]     dither;

    lfsr_dither #(
        .WIDTH (LFSR_WIDTH)
    ) u_lfsr_dither (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_lfsr (lfsr_val)
    );

    assign dither    = lfsr_val[DITH_W-1:0];
    // Only the value being truncated is dithered; acc_p0 and its carry are not
    assign acc_trunc = acc_p0 + ACC_WIDTH'(dither);
`else
    assign acc_trunc = acc_p0;
`endif

    // ---- stage p1: registered phase word, valid and wrap pulse ----

    // Output register: phase holds while disabled, valid/wrap drop to 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_phase <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            o_valid <= i_en;
            o_wrap  <= carry_p0 & i_en;
            if (i_en) begin
                o_phase <= phase_word(acc_trunc, i_phase_ofs);
            end
        end
    end

endmodule

// File: tb/tb_phase_accum_nco.sv
// Scoreboard bench for phase_accum_nco: drivers push hand-derived expected
// {wrap, phase} pairs into queues, monitors pop and compare on every o_valid.
module tb_phase_accum_nco;

    localparam logic [31:0] STEP1 = 32'h0040_0000;  // 1 phase LSB per cycle
    localparam logic [31:0] STEP2 = 32'h0080_0000;  // 2 phase LSB per cycle
    localparam logic [31:0] HALF  = 32'h8000_0000;  // wrap every other cycle

    logic        clk = 1'b0;

    // DUT a: update deferred to wrap
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ftw = '0;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic [9:0]  ofs = '0;
    logic [9:0]  phase;
    logic        valid;
    logic        wrap;

    // DUT b: update applied right after acceptance
    logic        b_rst = 1'b1;
    logic        b_en = 1'b0;
    logic        b_clear = 1'b0;
    logic [31:0] b_ftw = '0;
    logic        b_ftw_valid = 1'b0;
    logic        b_ftw_ready;
    logic [9:0]  b_ofs = '0;
    logic [9:0]  b_phase;
    logic        b_valid;
    logic        b_wrap;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [10:0] exp_q[$];
    logic [10:0] exp_qb[$];

    always #5 clk = ~clk;

    phase_accum_nco #(
        .ACC_WIDTH      (32),
        .PHASE_WIDTH    (10),
        .UPDATE_ON_WRAP (1)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_clear     (clear),
        .i_ftw       (ftw),
        .i_ftw_valid (ftw_valid),
        .o_ftw_ready (ftw_ready),
        .i_phase_ofs (ofs),
        .o_phase     (phase),
        .o_valid     (valid),
        .o_wrap      (wrap)
    );

    phase_accum_nco #(
        .ACC_WIDTH      (32),
        .PHASE_WIDTH    (10),
        .UPDATE_ON_WRAP (0)
    ) u_dut_b (
        .i_clk       (clk),
        .i_rst       (b_rst),
        .i_en        (b_en),
        .i_clear     (b_clear),
        .i_ftw       (b_ftw),
        .i_ftw_valid (b_ftw_valid),
        .o_ftw_ready (b_ftw_ready),
        .i_phase_ofs (b_ofs),
        .o_phase     (b_phase),
        .o_valid     (b_valid),
        .o_wrap      (b_wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {wrap, phase} when stepping 1 LSB for one period then 2 LSB;
    // m counts outputs since the accumulator was last zero.
    function automatic logic [10:0] exp_hop(input int m);
        int d;
        if (m <= 1024) begin
            return {(m == 1024), 10'(m % 1024)};
        end
        d = m - 1024;
        return {((d % 512) == 0), 10'((2 * d) % 1024)};
    endfunction

    // Monitor for DUT a
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("a_spurious_valid", 32'(valid), 32'd0);
            end else begin
                check("a_phase_wrap", 32'({wrap, phase}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for DUT b
    always @(negedge clk) begin
        if (b_valid === 1'b1) begin
            if (exp_qb.size() == 0) begin
                check("b_spurious_valid", 32'(b_valid), 32'd0);
            end else begin
                check("b_phase_wrap", 32'({b_wrap, b_phase}), 32'(exp_qb.pop_front()));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0; ftw_valid = 1'b0;
        tick();
        tick();
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_wrap",  32'(wrap),  32'd0);
        check("rst_ready", 32'(ftw_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(ftw_ready), 32'd1);
    endtask

    task automatic load_ftw(input logic [31:0] v);
        ftw = v; ftw_valid = 1'b1;
        tick();
        ftw_valid = 1'b0;
    endtask

    initial begin
        // Ramp at 1 LSB/cycle, zero offset
        do_reset();
        load_ftw(STEP1);
        for (int k = 0; k <= 1100; k++) begin
            en = 1'b1;
            exp_q.push_back({(k > 0 && (k % 1024) == 0), 10'(k % 1024)});
            tick();
        end
        en = 1'b0;
        tick(); tick();

        // Same ramp with a quarter-turn offset; wrap timing unchanged
        do_reset();
        load_ftw(STEP1);
        ofs = 10'd256;
        for (int k = 0; k <= 1100; k++) begin
            en = 1'b1;
            exp_q.push_back({(k > 0 && (k % 1024) == 0), 10'((k + 256) % 1024)});
            tick();
        end
        en = 1'b0; ofs = '0;
        tick(); tick();

        // Frequency hop deferred to the wrap
        do_reset();
        load_ftw(STEP1);
        for (int k = 0; k <= 2124; k++) begin
            en = 1'b1;
            ftw_valid = 1'b0;
            if (k == 101) begin
                check("hop_ready_before", 32'(ftw_ready), 32'd1);
                ftw = STEP2; ftw_valid = 1'b1;
            end
            if (k == 102)  check("hop_ready_pend",  32'(ftw_ready), 32'd0);
            if (k == 1023) check("hop_ready_last",  32'(ftw_ready), 32'd0);
            if (k == 1024) check("hop_ready_after", 32'(ftw_ready), 32'd1);
            exp_q.push_back(exp_hop(k));
            tick();
        end
        en = 1'b0; ftw_valid = 1'b0;
        tick(); tick();

        // Clear while the hop is pending: phase restarts, hop waits for wrap
        do_reset();
        load_ftw(STEP1);
        for (int k = 0; k <= 1566; k++) begin
            en = 1'b1;
            ftw_valid = 1'b0;
            clear = (k == 501);
            if (k == 101) begin
                ftw = STEP2; ftw_valid = 1'b1;
            end
            if (k == 900)  check("clr_ready_pend",  32'(ftw_ready), 32'd0);
            if (k == 1525) check("clr_ready_last",  32'(ftw_ready), 32'd0);
            if (k == 1526) check("clr_ready_after", 32'(ftw_ready), 32'd1);
            exp_q.push_back((k <= 501) ? exp_hop(k) : exp_hop(k - 502));
            tick();
        end
        en = 1'b0; clear = 1'b0; ftw_valid = 1'b0;
        tick(); tick();

        // Reset in the middle of a run
        do_reset();
        load_ftw(STEP1);
        for (int k = 0; k <= 700; k++) begin
            en = 1'b1;
            exp_q.push_back({1'b0, 10'(k)});
            tick();
        end
        rst = 1'b1;
        tick();
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_wrap",  32'(wrap),  32'd0);
        check("midrst_ready", 32'(ftw_ready), 32'd0);
        rst = 1'b0; en = 1'b0;
        tick();
        check("midrst_ready_next", 32'(ftw_ready), 32'd1);

        // Back in IDLE: word loads directly; half-scale word wraps every other cycle
        load_ftw(HALF);
        for (int k = 0; k <= 8; k++) begin
            en = 1'b1;
            exp_q.push_back({(k > 0 && (k % 2) == 0), ((k % 2) == 1) ? 10'd512 : 10'd0});
            tick();
        end
        en = 1'b0;
        tick(); tick();

        // Immediate update: step changes two outputs after acceptance
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        tick();
        b_ftw = STEP1; b_ftw_valid = 1'b1;
        tick();
        b_ftw_valid = 1'b0;
        for (int k = 0; k <= 300; k++) begin
            b_en = 1'b1;
            b_ftw_valid = 1'b0;
            if (k == 101) begin
                b_ftw = STEP2; b_ftw_valid = 1'b1;
            end
            if (k == 102) check("b_ready_after", 32'(b_ftw_ready), 32'd1);
            exp_qb.push_back({1'b0, (k <= 102) ? 10'(k) : 10'(102 + 2 * (k - 102))});
            tick();
        end
        b_en = 1'b0; b_ftw_valid = 1'b0;
        tick(); tick(); tick();

        check("a_queue_drained", 32'(exp_q.size()), 32'd0);
        check("b_queue_drained", 32'(exp_qb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
